// File: rtl/neo_video_pkg.sv
// Shared definitions for the NeoGeo video output path: colour-word layout,
// palette RAM geometry and the CPU palette-port FSM states.
package neo_video_pkg;

    localparam int DARK = 15;
    localparam int R0   = 14;
    localparam int G0   = 13;
    localparam int B0   = 12;

    localparam int PAL_DEPTH = 8192;
    localparam int PAL_AW    = $clog2(PAL_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } cpu_state_e;

    function automatic logic [15:0] be_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  be);
        return {be[1] ? new_w[15:8] : old_w[15:8],
                be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

endpackage

// File: rtl/neo_palette_out_if.sv
// 68k palette access port at 0x40xxxx; the address itself travels on PA.
// Handshake: CPU_REQ is a level held until CPU_ACK pulses for one CLK; CPU_WE,
// CPU_BE and CPU_DIN are stable while CPU_REQ is high; CPU_DOUT is valid while CPU_ACK is high.
interface neo_palette_out_if;

    logic        CPU_REQ;
    logic        CPU_WE;
    logic [1:0]  CPU_BE;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_ACK;

    modport master (
        output CPU_REQ, CPU_WE, CPU_BE, CPU_DIN,
        input  CPU_DOUT, CPU_ACK
    );

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_BE, CPU_DIN,
        output CPU_DOUT, CPU_ACK
    );

endinterface

// File: rtl/palette_ram.sv
// Single-port 8192x16 palette RAM, byte-enable writes, read-first, 1-CLK read latency.
module palette_ram
    import neo_video_pkg::*;
(
    input  logic              clk,
    input  logic [PAL_AW-1:0] addr,
    input  logic [1:0]        we,
    input  logic [15:0]       din,
    output logic [15:0]       dout
);

    logic [15:0] mem [PAL_DEPTH];

    // Read-first: a write and a read of the same word in one cycle return the old word.
    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= din[7:0];
        if (we[1]) mem[addr][15:8] <= din[15:8];
        dout <= mem[addr];
    end

endmodule

// File: rtl/neo_palette_out.sv
// Palette lookup and RGB decode for the line-buffer mixer output, with a
// 68k palette port sharing the RAM in the cycles between pixel fetches.
module neo_palette_out
    import neo_video_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CE_PIX,
    input  logic [11:0]             PA,
    input  logic                    PALBNK,
    input  logic                    SHADOW,
    input  logic                    nBLANK,
    neo_palette_out_if.slave        cpu,
    output logic [7:0]              R,
    output logic [7:0]              G,
    output logic [7:0]              B,
    output logic                    DE,
    output cpu_state_e              dbg_state
);

    cpu_state_e        state;
    logic              cap_pend;
    logic              shadow_d;
    logic              nblank_d;
    logic [15:0]       pix_word;
    logic [15:0]       ram_dout;
    logic [1:0]        ram_we;
    logic [PAL_AW-1:0] ram_addr;

    // Video and CPU both address the RAM through PA, so no address mux is needed;
    // a pixel fetch landing on the ACCESS cycle simply shares that read.
    assign ram_addr  = {PALBNK, PA};
    assign ram_we    = (state == ST_ACCESS && cpu.CPU_WE) ? cpu.CPU_BE : 2'b00;
    assign dbg_state = state;

    palette_ram u_ram (
        .clk  (CLK),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (cpu.CPU_DIN),
        .dout (ram_dout)
    );

    logic [5:0] r6, g6, b6;
    logic [7:0] r8, g8, b8;

    assign r6 = {pix_word[11:8], pix_word[R0], ~pix_word[DARK]};
    assign g6 = {pix_word[7:4],  pix_word[G0], ~pix_word[DARK]};
    assign b6 = {pix_word[3:0],  pix_word[B0], ~pix_word[DARK]};

    // Shadow halves the 8-bit expansion {c6, c6[5:4]}.
    assign r8 = shadow_d ? {1'b0, r6, r6[5]} : {r6, r6[5:4]};
    assign g8 = shadow_d ? {1'b0, g6, g6[5]} : {g6, g6[5:4]};
    assign b8 = shadow_d ? {1'b0, b6, b6[5]} : {b6, b6[5:4]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_pend <= 1'b0;
            shadow_d <= 1'b0;
            nblank_d <= 1'b0;
            pix_word <= 16'h0000;
            R        <= 8'h00;
            G        <= 8'h00;
            B        <= 8'h00;
            DE       <= 1'b0;
        end else begin
            cap_pend <= CE_PIX;
            if (cap_pend) pix_word <= ram_dout;
            if (CE_PIX) begin
                shadow_d <= SHADOW;
                nblank_d <= nBLANK;
                R        <= nblank_d ? r8 : 8'h00;
                G        <= nblank_d ? g8 : 8'h00;
                B        <= nblank_d ? b8 : 8'h00;
                DE       <= nblank_d;
            end
        end
    end

    // A start is refused on a pixel slot and on the capture cycle that follows it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            cpu.CPU_ACK  <= 1'b0;
            cpu.CPU_DOUT <= 16'h0000;
        end else begin
            cpu.CPU_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu.CPU_REQ && !CE_PIX && !cap_pend) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    cpu.CPU_ACK  <= 1'b1;
                    cpu.CPU_DOUT <= cpu.CPU_WE ? be_merge(ram_dout, cpu.CPU_DIN, cpu.CPU_BE)
                                               : ram_dout;
                    state        <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!cpu.CPU_REQ) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neo_palette_out.sv
// Directed and randomized checks of neo_palette_out against a palette/colour model.
module tb_neo_palette_out;
  import neo_video_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE_PIX;
  logic [11:0] PA;
  logic        PALBNK;
  logic        SHADOW;
  logic        nBLANK;
  logic [7:0]  R, G, B;
  logic        DE;
  cpu_state_e  dbg_state;

  neo_palette_out_if cpu_bus ();

  int checks = 0;
  int errors = 0;

  logic [15:0] pal_m [PAL_DEPTH];
  logic [24:0] exp_now;
  logic [24:0] exp_next;
  logic [15:0] rd;

  neo_palette_out dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE_PIX    (CE_PIX),
    .PA        (PA),
    .PALBNK    (PALBNK),
    .SHADOW    (SHADOW),
    .nBLANK    (nBLANK),
    .cpu       (cpu_bus),
    .R         (R),
    .G         (G),
    .B         (B),
    .DE        (DE),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // Colour model: {R,G,B,DE} straight from the colour-word rules.
  function automatic logic [24:0] model_pix(input logic [15:0] w, input logic sh, input logic nb);
    int c5 [3];
    int ch [3];
    if (!nb) return 25'd0;
    c5[0] = int'(w[11:8]) * 2 + int'(w[14]);
    c5[1] = int'(w[7:4])  * 2 + int'(w[13]);
    c5[2] = int'(w[3:0])  * 2 + int'(w[12]);
    for (int i = 0; i < 3; i++) begin
      int c6;
      c6    = c5[i] * 2 + (w[15] ? 0 : 1);
      ch[i] = c6 * 4 + c6 / 16;
      if (sh) ch[i] = ch[i] / 2;
    end
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2]), 1'b1};
  endfunction

  function automatic logic [15:0] model_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                              input logic [1:0] be);
    logic [15:0] hi_m;
    logic [15:0] lo_m;
    hi_m = be[1] ? 16'hFF00 : 16'h0000;
    lo_m = be[0] ? 16'h00FF : 16'h0000;
    return (new_w & (hi_m | lo_m)) | (old_w & ~(hi_m | lo_m));
  endfunction

  // Latency from the first edge that samples CPU_REQ: 2, +1 for a pixel slot, +1 for its capture.
  function automatic int exp_lat(input int ce_mode);
    case (ce_mode)
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // driver tasks
  task automatic ce_begin();
    exp_now  = exp_next;
    exp_next = model_pix(pal_m[{PALBNK, PA}], SHADOW, nBLANK);
    CE_PIX   = 1'b1;
  endtask

  task automatic ce_end();
    CE_PIX = 1'b0;
    check("pixel", 32'({R, G, B, DE}), 32'(exp_now));
  endtask

  task automatic pix();
    ce_begin();
    tick();
    ce_end();
    tick();
    tick();
  endtask

  // ce_mode: 0 none, 1 pixel on first REQ edge, 2 pixel one edge earlier, 3 pixel on ACCESS edge
  task automatic cpu_access(input logic we, input logic [1:0] be, input logic bank,
                            input logic [11:0] addr, input logic [15:0] din, input int ce_mode,
                            output logic [15:0] rd_o);
    int          n;
    int          acks;
    logic        got;
    logic [15:0] exp_dout;
    logic [12:0] ma;
    ma = {bank, addr};
    PA = addr;
    PALBNK = bank;
    cpu_bus.CPU_WE  = we;
    cpu_bus.CPU_BE  = be;
    cpu_bus.CPU_DIN = din;
    if (ce_mode == 2) begin
      ce_begin();
      tick();
      ce_end();
    end
    cpu_bus.CPU_REQ = 1'b1;
    if (ce_mode == 1) ce_begin();
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      if (ce_mode == 3 && n == 1) ce_begin();
      tick();
      n++;
      if (CE_PIX) ce_end();
      if (cpu_bus.CPU_ACK) got = 1'b1;
    end
    rd_o = cpu_bus.CPU_DOUT;
    check("ack_seen", 32'(got), 32'(1));
    exp_dout = we ? model_merge(pal_m[ma], din, be) : pal_m[ma];
    check("ack_latency", 32'(n - 1), 32'(exp_lat(ce_mode)));
    check("cpu_dout", 32'(rd_o), 32'(exp_dout));
    if (we) pal_m[ma] = exp_dout;
    acks = got ? 1 : 0;
    repeat (3) begin
      tick();
      if (cpu_bus.CPU_ACK) acks++;
    end
    check("ack_pulses", 32'(acks), 32'(1));
    cpu_bus.CPU_REQ = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    int acks;
    RST = 1'b1;
    CE_PIX = 1'b0;
    PA = 12'h000;
    PALBNK = 1'b0;
    SHADOW = 1'b0;
    nBLANK = 1'b0;
    cpu_bus.CPU_REQ = 1'b0;
    cpu_bus.CPU_WE  = 1'b0;
    cpu_bus.CPU_BE  = 2'b00;
    cpu_bus.CPU_DIN = 16'h0000;
    exp_now  = 25'd0;
    exp_next = 25'd0;
    for (int i = 0; i < PAL_DEPTH; i++) pal_m[i] = 16'h0000;

    repeat (3) tick();
    check("reset_rgbde", 32'({R, G, B, DE}), 32'(0));
    check("reset_ack", 32'(cpu_bus.CPU_ACK), 32'(0));
    check("reset_dout", 32'(cpu_bus.CPU_DOUT), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    RST = 1'b0;
    tick();

    // white, dark black, red, shadowed red
    cpu_access(1'b1, 2'b11, 1'b0, 12'h001, 16'h7FFF, 0, rd);
    PA = 12'h001; PALBNK = 1'b0; nBLANK = 1'b1; SHADOW = 1'b0;
    pix(); pix();
    check("white_rgb", 32'({R, G, B}), 32'h00FFFFFF);
    check("white_de", 32'(DE), 32'(1));
    cpu_access(1'b1, 2'b11, 1'b0, 12'h010, 16'h8000, 0, rd);
    PA = 12'h010;
    pix(); pix();
    check("dark_black", 32'({R, G, B}), 32'h0);
    cpu_access(1'b1, 2'b11, 1'b0, 12'h010, 16'h0F00, 0, rd);
    PA = 12'h010;
    pix(); pix();
    check("red_rgb", 32'({R, G, B}), 32'h00F70404);
    SHADOW = 1'b1;
    pix(); pix();
    check("red_shadow", 32'({R, G, B}), 32'h007B0202);
    nBLANK = 1'b0;
    pix();
    check("blank_lag_de", 32'(DE), 32'(1));
    pix();
    check("blank_rgbde", 32'({R, G, B, DE}), 32'h0);

    // banks and byte enables
    SHADOW = 1'b0; nBLANK = 1'b1;
    cpu_access(1'b1, 2'b11, 1'b0, 12'h005, 16'h1234, 0, rd);
    cpu_access(1'b1, 2'b11, 1'b1, 12'h005, 16'h4321, 0, rd);
    cpu_access(1'b0, 2'b11, 1'b0, 12'h005, 16'h0000, 0, rd);
    check("bank0_read", 32'(rd), 32'h1234);
    cpu_access(1'b0, 2'b11, 1'b1, 12'h005, 16'h0000, 0, rd);
    check("bank1_read", 32'(rd), 32'h4321);
    cpu_access(1'b1, 2'b01, 1'b0, 12'h005, 16'hABCD, 0, rd);
    cpu_access(1'b0, 2'b11, 1'b0, 12'h005, 16'h0000, 0, rd);
    check("byte_merge", 32'(rd), 32'h12CD);
    PA = 12'h005; PALBNK = 1'b1;
    pix(); pix();
    PALBNK = 1'b0;
    pix(); pix();

    // pixel slot contention
    cpu_access(1'b0, 2'b11, 1'b0, 12'h005, 16'h0000, 1, rd);
    cpu_access(1'b0, 2'b11, 1'b0, 12'h005, 16'h0000, 2, rd);
    cpu_access(1'b1, 2'b11, 1'b0, 12'h001, 16'h0123, 3, rd);
    pix(); pix();

    // reset during ACCESS
    PA = 12'h005; PALBNK = 1'b0;
    cpu_bus.CPU_WE = 1'b0;
    cpu_bus.CPU_REQ = 1'b1;
    n = 0;
    while (dbg_state != ST_ACCESS && n < 6) begin
      tick();
      n++;
    end
    check("reach_access", 32'(dbg_state), 32'(ST_ACCESS));
    RST = 1'b1;
    #1;
    check("rst_rgbde", 32'({R, G, B, DE}), 32'h0);
    check("rst_ack", 32'(cpu_bus.CPU_ACK), 32'(0));
    check("rst_dout", 32'(cpu_bus.CPU_DOUT), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cpu_bus.CPU_REQ = 1'b0;
    tick();
    RST = 1'b0;
    exp_now = 25'd0;
    exp_next = 25'd0;
    acks = 0;
    repeat (3) begin
      tick();
      if (cpu_bus.CPU_ACK) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'(0));
    cpu_access(1'b0, 2'b11, 1'b0, 12'h005, 16'h0000, 0, rd);
    pix(); pix();

    // randomized: fill a small window in both banks, then mixed traffic
    nBLANK = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 2; b++) begin
        cpu_access(1'b1, 2'b11, 1'(b), 12'h100 + 12'(i), 16'($urandom),
                   int'($urandom_range(0, 3)), rd);
      end
    end
    for (int k = 0; k < 24; k++) begin
      int          op;
      logic [11:0] a;
      logic        bk;
      op = int'($urandom_range(0, 2));
      a  = 12'h100 + 12'($urandom_range(0, 7));
      bk = 1'($urandom_range(0, 1));
      SHADOW = 1'($urandom_range(0, 1));
      nBLANK = 1'($urandom_range(0, 1));
      case (op)
        0: cpu_access(1'b1, 2'($urandom_range(1, 3)), bk, a, 16'($urandom),
                      int'($urandom_range(0, 3)), rd);
        1: cpu_access(1'b0, 2'b11, bk, a, 16'h0000, int'($urandom_range(0, 3)), rd);
        default: begin
          PA = a;
          PALBNK = bk;
          pix(); pix();
        end
      endcase
    end

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
